// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-port round-robin arbiter and cycle sequencer for a 16-bit asynchronous
// SRAM. One access is in flight at a time. Every access is followed by at
// least one IDLE cycle, and that cycle doubles as the DQ bus turnaround.
//
// Parameters
//   ACCESS_CYCLES  clock cycles the SRAM is strobed per access (1..15)
//   ADDR_W         SRAM word-address width
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   req[1:0]       per-port request, held until the matching gnt bit
//   we[1:0]        per-port write (1) / read (0)
//   addr0/addr1    per-port word address
//   wdata0/wdata1  per-port write data
//   be0/be1        per-port byte enables, [1] upper byte, [0] lower byte
//   gnt[1:0]       one-hot acceptance pulse, combinational in IDLE
//   rvalid[1:0]    one-hot read-data-valid pulse
//   rdata          registered read data, valid with any rvalid bit
//   SRAM_*         SRAM pins; strobes are active-low and registered
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata0,
    input  logic [15:0]       wdata1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              prio, prio_nxt;
    logic              owner, owner_nxt;
    logic              acc_we, acc_we_nxt;
    logic [1:0]        acc_be, acc_be_nxt;
    logic [15:0]       acc_wdata, acc_wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              winner;
    logic              dq_oe;

    // Strobe values for the cycle after the current edge
    logic              in_access_nxt;
    logic              ce_n_nxt;
    logic              oe_n_nxt;
    logic              we_n_nxt;
    logic              ub_n_nxt;
    logic              lb_n_nxt;
    logic              dq_oe_nxt;
    logic              read_done;

    // Contention goes to the pointer; a lone requester always wins.
    always_comb begin
        if (req == 2'b11) begin
            winner = prio;
        end else begin
            winner = req[1];
        end
    end

    // Next-state and grant logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        prio_nxt      = prio;
        owner_nxt     = owner;
        acc_we_nxt    = acc_we;
        acc_be_nxt    = acc_be;
        acc_wdata_nxt = acc_wdata;
        addr_nxt      = SRAM_ADDR;
        gnt           = 2'b00;

        case (state)
            IDLE: begin
                // Gated by reset so a held request is never acknowledged
                // while the sequencer is being cleared.
                if ((|req) && !reset) begin
                    gnt           = winner ? 2'b10 : 2'b01;
                    state_nxt     = ACCESS;
                    cnt_nxt       = CNT_LOAD;
                    prio_nxt      = ~winner;
                    owner_nxt     = winner;
                    acc_we_nxt    = we[winner];
                    acc_be_nxt    = winner ? be1 : be0;
                    acc_wdata_nxt = winner ? wdata1 : wdata0;
                    addr_nxt      = winner ? addr1 : addr0;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered from next-state values so the pins are clean
    // flop outputs, and the async reset forces them inactive immediately.
    // WE_N releases one cycle early so the last ACCESS cycle holds address
    // and data stable past the write edge; a single-cycle access has no
    // room for that and strobes WE_N for the whole cycle.
    always_comb begin
        in_access_nxt = (state_nxt == ACCESS);
        ce_n_nxt      = ~in_access_nxt;
        oe_n_nxt      = ~(in_access_nxt && !acc_we_nxt);
        we_n_nxt      = ~(in_access_nxt && acc_we_nxt &&
                          ((cnt_nxt != 4'd0) || (ACCESS_CYCLES == 1)));
        ub_n_nxt      = ~(in_access_nxt && acc_be_nxt[1]);
        lb_n_nxt      = ~(in_access_nxt && acc_be_nxt[0]);
        dq_oe_nxt     = in_access_nxt && acc_we_nxt;
    end

    assign read_done = (state == ACCESS) && (cnt == 4'd0) && !acc_we;

    // Control, address, strobe and read-return registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            prio      <= 1'b0;
            owner     <= 1'b0;
            acc_we    <= 1'b0;
            acc_be    <= 2'b00;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            rvalid    <= 2'b00;
            rdata     <= 16'h0000;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            prio      <= prio_nxt;
            owner     <= owner_nxt;
            acc_we    <= acc_we_nxt;
            acc_be    <= acc_be_nxt;
            SRAM_ADDR <= addr_nxt;
            SRAM_CE_N <= ce_n_nxt;
            SRAM_OE_N <= oe_n_nxt;
            SRAM_WE_N <= we_n_nxt;
            SRAM_UB_N <= ub_n_nxt;
            SRAM_LB_N <= lb_n_nxt;
            dq_oe     <= dq_oe_nxt;
            rvalid    <= read_done ? (owner ? 2'b10 : 2'b01) : 2'b00;
            if (read_done) begin
                rdata <= SRAM_DQ;
            end
        end
    end

    // Write data needs no reset: it only reaches the pins behind dq_oe.
    always_ff @(posedge clk) begin
        acc_wdata <= acc_wdata_nxt;
    end

    assign SRAM_DQ = dq_oe ? acc_wdata : 16'hzzzz;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's 16-bit asynchronous SRAM (1M x 16, pins SRAM_ADDR/DQ/CE_N/OE_N/WE_N/UB_N/LB_N). It sits between two on-chip requesters (port 0, e.g. a video pixel fetcher; port 1, e.g. a host bridge) and the SRAM pins. It grants one access at a time using round-robin arbitration and generates multi-cycle read/write strobes with a bus-turnaround gap.

## Interface
- ACCESS_CYCLES, 2: clock cycles the SRAM is strobed per access; legal range 1..15.
- ADDR_W, 20: SRAM word-address width.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-port request; held with its qualifiers until the matching gnt bit is seen.
- we  in  2  per-port write (1) / read (0).
- addr0, addr1  in  ADDR_W each  per-port word address.
- wdata0, wdata1  in  16 each  per-port write data.
- be0, be1  in  2 each  per-port byte enables; [1] is the upper byte, [0] the lower byte.
- gnt  out  2  one-hot, 1-cycle acceptance pulse; combinational in IDLE.
- rvalid  out  2  one-hot, 1-cycle read-data-valid pulse.
- rdata  out  16  registered read data; valid when any rvalid bit is high.
- SRAM_ADDR  out  ADDR_W  registered address.
- SRAM_DQ  inout  16  data bus; high-Z except while a write is in ACCESS.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes.

## Operation
- FSM states: IDLE and ACCESS.
- **IDLE**
  - All strobes are high and DQ is high-Z.
  - If any req bit is set, the arbiter picks a winner, asserts gnt[winner] in the same cycle, and latches addr/wdata/be/we from the winning port. It loads cnt = ACCESS_CYCLES-1 and moves to ACCESS.
- **Arbitration**
  - A 1-bit priority pointer `prio` is 0 at reset.
  - Only one port requesting: that port wins.
  - Both ports requesting: port `prio` wins.
  - After every grant, `prio` is set to the port that did not win.
- **ACCESS**
  - SRAM_ADDR = latched addr, CE_N = 0, UB_N = ~be[1], LB_N = ~be[0].
  - Read: OE_N = 0 for every ACCESS cycle.
  - Write: DQ is driven with latched wdata for every ACCESS cycle. WE_N = 0 for every ACCESS cycle except the last, which provides address/data hold. When ACCESS_CYCLES = 1, WE_N = 0 for that single cycle.
  - cnt decrements each cycle. When cnt = 0:
    - Read: SRAM_DQ is captured into rdata, and rvalid[owner] is set for the next cycle.
    - Both reads and writes then return to IDLE.
- The mandatory IDLE cycle between accesses is the DQ turnaround: DQ is never driven in two consecutive accesses without one high-Z cycle between them.
- be = 2'b00 is still granted and sequenced, with both byte strobes high. A read with be = 2'b00 still pulses rvalid, and rdata is undefined.
- Writes have no completion pulse; gnt is the only acknowledgement.
- Reset values: gnt = 0, rvalid = 0, rdata = 0, SRAM_ADDR = 0, all *_N = 1, DQ high-Z, state = IDLE, prio = 0, cnt = 0.
- Reset mid-access immediately deasserts all strobes and releases DQ. The interrupted access is dropped: no rvalid is issued, and the SRAM write contents at that address are undefined.

## Timing
- Request seen in IDLE at cycle T: gnt at T, ACCESS in cycles T+1..T+ACCESS_CYCLES, rvalid and rdata at T+ACCESS_CYCLES+1.
- The next gnt can occur at T+ACCESS_CYCLES+1, the same cycle as rvalid. Its ACCESS begins at T+ACCESS_CYCLES+2.
- Peak throughput is one access per ACCESS_CYCLES+1 cycles, and is the same under contention.
- Worst-case wait for a continuously requesting port is one access from the other port (ACCESS_CYCLES+1 cycles).
- Requests arriving during ACCESS are not sampled until the next IDLE cycle.
- gnt is never asserted outside IDLE.

## Test plan
1. ACCESS_CYCLES=2: port 0 reads addr 0x00010 (SRAM model holds 0xBEEF) -> gnt[0] at T; CE_N=OE_N=0 at T+1..T+2; rvalid[0] with rdata=0xBEEF at T+3.
2. Port 1 writes 0x1234 to 0x00020 with be=2'b11, then port 1 reads 0x00020 -> WE_N low only at T+1, DQ driven T+1..T+2, DQ high-Z at T+3, read returns 0x1234; no cycle has DQ driven by both the FPGA and the model.
3. Both ports request reads continuously from reset -> grants alternate 0,1,0,1; each gnt is 3 cycles apart; rvalid bits alternate in the same order.
4. Byte write of 0xAA55 with be=2'b01 over existing 0xFFFF -> UB_N=1, LB_N=0 during ACCESS; readback = 0xFF55.
5. Assert reset at T+1 of a write -> all strobes high and DQ high-Z in the same cycle; no rvalid; after release, a new request is granted on its first IDLE cycle.
6. ACCESS_CYCLES=1: single read then write back-to-back -> gnt at T and T+2; WE_N low for exactly 1 cycle; rvalid at T+2.
